pc_sequencer: RTL and testbench

Fetch/issue controller that owns the program counter and sequences instruction fetch for the single-issue core. Each cycle it chooses the next PC from three sources: sequential PC+4, branch target (PC+4 + (sign-extended immediate << 2)), or absolute jump target. It runs a one-outstanding request/acknowledge handshake to instruction memory, then a valid/ready handshake to decode. This replaces the free-running PC register with a stall-aware sequencer.

---
 rtl/pc_sequencer.sv | 96 +++++++++
 tb/tb_pc_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: stall-aware PC owner that fetches one instruction at a time and issues it to decode.
// Optional retire counter output enabled by defining PC_RETIRE_CNT_EN.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        jump_en,
   input  logic [31:0] jump_target,
   input  logic        branch_taken,
   input  logic [31:0] branch_imm,
   input  logic        halt
`ifdef PC_RETIRE_CNT_EN
   ,output logic [31:0] retire_count
`endif
);
   typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALTED} state_t;
   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, instr_q, instr_d, ipc_q, ipc_d, next_pc;
   logic        req_q, req_d, valid_q, valid_d, fetch_ack, issue_hs;
   assign fetch_ack = req_q & imem_ack;
   assign issue_hs  = valid_q & instr_ready;
   assign next_pc   = jump_en      ? (jump_target & ~32'd3) :
                      branch_taken ? ipc_q + 32'd4 + (branch_imm << 2) :
                                     ipc_q + 32'd4;
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      req_d   = req_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: begin
            state_d = FETCH;
            req_d   = 1'b1;
         end
         FETCH: if (fetch_ack) begin
            state_d = ISSUE;
            instr_d = imem_rdata;
            ipc_d   = pc_q;
            req_d   = 1'b0;
            valid_d = 1'b1;
         end
         ISSUE: if (issue_hs) begin
            state_d = halt ? HALTED : FETCH;
            pc_d    = next_pc;
            req_d   = ~halt;
            valid_d = 1'b0;
         end
         default: begin
            req_d   = 1'b0;
            valid_d = 1'b0;
         end
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         ipc_q   <= '0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         req_q   <= req_d;
         valid_q <= valid_d;
      end
   end
   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign instr_pc    = ipc_q;
   assign instr_valid = valid_q;
`ifdef PC_RETIRE_CNT_EN
   logic [31:0] cnt_q, cnt_d;
   assign cnt_d = cnt_q + 32'(issue_hs);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign retire_count = cnt_q;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed stimulus with a handshake-level reference model checked every cycle.
module tb_pc_sequencer;
   logic        clk, rst_n, imem_req, imem_ack, instr_valid, instr_ready;
   logic        jump_en, branch_taken, halt;
   logic [31:0] imem_addr, imem_rdata, instr, instr_pc, jump_target, branch_imm;
`ifdef PC_RETIRE_CNT_EN
   logic [31:0] retire_count;
`endif
   int errors = 0, checks = 0;
   int ack_delay = 0;
   bit spurious = 0;

   pc_sequencer #(.RESET_PC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .jump_en(jump_en),
      .jump_target(jump_target), .branch_taken(branch_taken), .branch_imm(branch_imm),
      .halt(halt)
`ifdef PC_RETIRE_CNT_EN
      ,.retire_count(retire_count)
`endif
   );

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // memory responder: acks after ack_delay wait cycles of a held request
   initial begin
      int w = 0;
      imem_ack = 0;
      imem_rdata = 0;
      forever begin
         @(posedge clk);
         #2;
         if (imem_req) begin
            w++;
            imem_ack = (w > ack_delay);
            imem_rdata = mem(imem_addr);
         end else begin
            w = 0;
            imem_ack = spurious;
            imem_rdata = 32'hDEAD_BEEF;
         end
      end
   end

   // reference model: tracks what the next fetch address and issued word must be
   logic [31:0] m_pc, m_instr, m_ipc, m_cnt;
   bit m_halted, m_req_exp, m_val_exp, m_idle;
   always @(negedge clk) begin
      if (!rst_n) begin
         m_pc = 0; m_halted = 0; m_req_exp = 0; m_val_exp = 0; m_idle = 1; m_cnt = 0;
         chk("rst_req", 32'(imem_req), 0);
         chk("rst_valid", 32'(instr_valid), 0);
      end else begin
         chk("req", 32'(imem_req), 32'(m_req_exp));
         chk("valid", 32'(instr_valid), 32'(m_val_exp));
         if (imem_req) chk("addr", imem_addr, m_pc);
         if (instr_valid) begin
            chk("instr", instr, m_instr);
            chk("instr_pc", instr_pc, m_ipc);
         end
`ifdef PC_RETIRE_CNT_EN
         chk("retire_count", retire_count, m_cnt);
`endif
         if (m_idle) begin
            m_idle = 0; m_req_exp = 1; m_val_exp = 0;
         end else if (imem_req && imem_ack) begin
            m_instr = imem_rdata; m_ipc = m_pc; m_req_exp = 0; m_val_exp = 1;
         end else if (imem_req) begin
            m_req_exp = 1; m_val_exp = 0;
         end else if (instr_valid && instr_ready) begin
            m_cnt++;
            m_pc = jump_en ? {jump_target[31:2], 2'b00} :
                   branch_taken ? m_ipc + 32'd4 + branch_imm * 32'd4 : m_ipc + 32'd4;
            m_halted = halt; m_req_exp = !halt; m_val_exp = 0;
         end else if (instr_valid) begin
            m_req_exp = 0; m_val_exp = 1;
         end else begin
            m_req_exp = 0; m_val_exp = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_fetch(output logic [31:0] a);
      int n = 0;
      while (!imem_req && n < 50) begin tick(); n++; end
      if (!imem_req) chk("fetch_timeout", 32'(imem_req), 1);
      a = imem_addr;
   endtask

   task automatic do_issue(input bit j, input logic [31:0] jt, input bit b,
                           input logic [31:0] bi, input bit h);
      int n = 0;
      while (!instr_valid && n < 50) begin tick(); n++; end
      if (!instr_valid) chk("issue_timeout", 32'(instr_valid), 1);
      jump_en = j; jump_target = jt; branch_taken = b; branch_imm = bi; halt = h;
      instr_ready = 1;
      tick();
      instr_ready = 0; jump_en = 0; branch_taken = 0; halt = 0;
      jump_target = 32'h5555_5555; branch_imm = 32'h7;
   endtask

   initial begin
      logic [31:0] a, si, sp;
      int cnt;
      rst_n = 0; instr_ready = 1; jump_en = 0; branch_taken = 0; halt = 0;
      jump_target = 0; branch_imm = 0;
      #3;
      chk("reset_req", 32'(imem_req), 0);
      chk("reset_addr", imem_addr, 32'h0);
      chk("reset_instr", instr, 0);
      chk("reset_instr_pc", instr_pc, 0);
      chk("reset_valid", 32'(instr_valid), 0);
      tick(); tick();
      rst_n = 1;
      for (int i = 0; i < 4; i++) begin
         wait_fetch(a);
         chk("seq_addr", a, 32'(i * 4));
         tick();
      end
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (instr_valid) cnt++;
         tick();
      end
      chk("seq_valid_rate", 32'(cnt), 4);
      instr_ready = 0;
      do_issue(1, 32'h100, 0, 0, 0);
      wait_fetch(a); chk("jump_0x100", a, 32'h100);
      do_issue(0, 0, 1, 32'hFFFF_FFFE, 0);
      wait_fetch(a); chk("branch_back", a, 32'h0FC);
      do_issue(1, 32'h100, 0, 0, 0);
      wait_fetch(a); chk("jump_0x100b", a, 32'h100);
      do_issue(0, 0, 1, 32'd5, 0);
      wait_fetch(a); chk("branch_fwd", a, 32'h118);
      do_issue(1, 32'h0000_2003, 1, 32'd5, 0);
      wait_fetch(a); chk("jump_priority", a, 32'h2000);
      do_issue(1, 32'hFFFF_FFFC, 0, 0, 0);
      wait_fetch(a); chk("jump_top", a, 32'hFFFF_FFFC);
      do_issue(0, 0, 0, 0, 0);
      wait_fetch(a); chk("wrap", a, 32'h0);
      ack_delay = 2;
      do_issue(0, 0, 0, 0, 0);
      wait_fetch(a); chk("wait_addr", a, 32'h4);
      cnt = 0;
      while (imem_req && cnt < 20) begin
         if (imem_addr !== 32'h4) chk("wait_addr_stable", imem_addr, 32'h4);
         cnt++;
         tick();
      end
      chk("wait_req_cycles", 32'(cnt), 3);
      chk("wait_valid", 32'(instr_valid), 1);
      chk("wait_instr", instr, 32'h0004_FFFB);
      chk("wait_instr_pc", instr_pc, 32'h4);
      ack_delay = 0;
      spurious = 1;
      si = instr; sp = instr_pc;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("stall_instr", instr, si);
         chk("stall_pc", instr_pc, sp);
         chk("stall_no_req", 32'(imem_req), 0);
      end
      spurious = 0;
      ack_delay = 5;
      do_issue(0, 0, 0, 0, 0);
      wait_fetch(a); chk("pre_reset_addr", a, 32'h8);
      tick();
      #2 rst_n = 0;
      #1;
      chk("async_rst_req", 32'(imem_req), 0);
      chk("async_rst_addr", imem_addr, 32'h0);
      tick();
      rst_n = 1; ack_delay = 0;
      wait_fetch(a); chk("restart_addr", a, 32'h0);
      do_issue(1, 32'h40, 0, 0, 1);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (imem_req || instr_valid) cnt++;
         tick();
      end
      chk("halted_quiet", 32'(cnt), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
